ddr_app_mem_model: RTL and testbench

- Synthesizable responder for the MIG user (app) interface: the memory-controller end of the port that the DDR write/read FSM drives.
- BRAM-backed. Replaces the MIG core in simulation and in loop-back bring-up builds, so the upstream DDR control path runs without external DDR3.
- Provides the calibration delay, command/write-data acceptance with backpressure, in-order execution, and fixed-latency read return.

---
 rtl/ddr_app_mem_model.sv | 130 +++++++++++++
 tb/tb_ddr_app_mem_model.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_app_mem_model.sv
// BRAM-backed stand-in for the MIG app interface: calibration delay,
// 4-deep command/write-data FIFOs, in-order execution, fixed-latency reads.
module ddr_app_mem_model #(
  parameter int ADDR_WIDTH       = 30,
  parameter int MEM_AW           = 10,
  parameter int RD_LATENCY       = 4,
  parameter int CALIB_DELAY      = 64,
  parameter int RDY_STALL_PERIOD = 0
) (
  input  logic                  ddr_ui_clk,
  input  logic                  ddr_log_rst,
  input  logic [ADDR_WIDTH-1:0] app_addr,
  input  logic [2:0]            app_cmd,
  input  logic                  app_en,
  input  logic [511:0]          app_wdf_data,
  input  logic                  app_wdf_end,
  input  logic                  app_wdf_wren,
  output logic [511:0]          app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rdy,
  output logic                  app_wdf_rdy,
  output logic                  init_calib_complete,
  output logic [31:0]           o_wr_cnt,
  output logic [31:0]           o_rd_cnt,
  output logic                  o_err
);

  localparam logic [2:0] CMD_WR = 3'd0;
  localparam logic [2:0] CMD_RD = 3'd1;

  logic              calib;
  logic [31:0]       cal_cnt;
  logic [31:0]       stall_cnt;
  logic              stall_cycle;

  logic [2:0]        cq_cmd [4];
  logic [MEM_AW-1:0] cq_idx [4];
  logic [1:0]        cq_wp, cq_rp;
  logic [2:0]        cq_cnt;

  logic [511:0]      wq [4];
  logic [1:0]        wq_wp, wq_rp;
  logic [2:0]        wq_cnt;

  logic [511:0]      mem [2**MEM_AW];
  logic [511:0]      pd [RD_LATENCY];
  logic [RD_LATENCY-1:0] pv;

  logic              cmd_push, wd_push, cmd_pop;
  logic              head_v;
  logic [2:0]        head_cmd;
  logic [MEM_AW-1:0] head_idx;
  logic              exec_wr, exec_rd, exec_bad;
  logic              unused_addr;

  assign unused_addr = ^{app_addr[ADDR_WIDTH-1:MEM_AW+3], app_addr[2:0]};

  assign stall_cycle = (RDY_STALL_PERIOD > 1) && (stall_cnt == 32'd0);
  assign init_calib_complete = calib;
  assign app_rdy     = calib && (cq_cnt != 3'd4) && !stall_cycle;
  assign app_wdf_rdy = calib && (wq_cnt != 3'd4);
  assign cmd_push    = app_en && app_rdy;
  assign wd_push     = app_wdf_wren && app_wdf_rdy;

  assign head_v   = (cq_cnt != 3'd0);
  assign head_cmd = cq_cmd[cq_rp];
  assign head_idx = cq_idx[cq_rp];

  // A write at the head stalls everything behind it until its data shows up
  assign exec_wr  = head_v && (head_cmd == CMD_WR) && (wq_cnt != 3'd0);
  assign exec_rd  = head_v && (head_cmd == CMD_RD);
  assign exec_bad = head_v && (head_cmd != CMD_WR) && (head_cmd != CMD_RD);
  assign cmd_pop  = exec_wr || exec_rd || exec_bad;

  always_ff @(posedge ddr_ui_clk) begin
    if (cmd_push) begin
      cq_cmd[cq_wp] <= app_cmd;
      cq_idx[cq_wp] <= app_addr[MEM_AW+2:3];
    end
    if (wd_push) wq[wq_wp] <= app_wdf_data;
    if (exec_wr) mem[head_idx] <= wq[wq_rp];
    pd[0] <= mem[head_idx];
    for (int i = 1; i < RD_LATENCY; i++) pd[i] <= pd[i-1];
  end

  always_ff @(posedge ddr_ui_clk or posedge ddr_log_rst) begin
    if (ddr_log_rst) begin
      calib             <= 1'b0;
      cal_cnt           <= '0;
      stall_cnt         <= '0;
      cq_wp             <= '0;
      cq_rp             <= '0;
      cq_cnt            <= '0;
      wq_wp             <= '0;
      wq_rp             <= '0;
      wq_cnt            <= '0;
      pv                <= '0;
      app_rd_data       <= '0;
      app_rd_data_valid <= 1'b0;
      o_wr_cnt          <= '0;
      o_rd_cnt          <= '0;
      o_err             <= 1'b0;
    end else begin
      if (!calib) begin
        if (cal_cnt == 32'(CALIB_DELAY - 1)) calib <= 1'b1;
        else cal_cnt <= cal_cnt + 32'd1;
      end
      if (stall_cnt == 32'(RDY_STALL_PERIOD - 1)) stall_cnt <= '0;
      else stall_cnt <= stall_cnt + 32'd1;

      if (cmd_push) cq_wp <= cq_wp + 2'd1;
      if (cmd_pop)  cq_rp <= cq_rp + 2'd1;
      cq_cnt <= cq_cnt + {2'b0, cmd_push} - {2'b0, cmd_pop};

      if (wd_push) wq_wp <= wq_wp + 2'd1;
      if (exec_wr) wq_rp <= wq_rp + 2'd1;
      wq_cnt <= wq_cnt + {2'b0, wd_push} - {2'b0, exec_wr};

      pv[0] <= exec_rd;
      for (int i = 1; i < RD_LATENCY; i++) pv[i] <= pv[i-1];
      app_rd_data_valid <= pv[RD_LATENCY-1];
      if (pv[RD_LATENCY-1]) app_rd_data <= pd[RD_LATENCY-1];

      if (exec_wr) o_wr_cnt <= o_wr_cnt + 32'd1;
      if (exec_rd) o_rd_cnt <= o_rd_cnt + 32'd1;
      if (exec_bad || (wd_push && !app_wdf_end)) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_app_mem_model.sv
// Scoreboard bench for ddr_app_mem_model: directed traffic, queued
// expected read data, independent monitor on app_rd_data_valid.
module tb_ddr_app_mem_model;

  logic         ddr_ui_clk = 1'b0;
  logic         ddr_log_rst = 1'b1;
  logic [29:0]  app_addr = '0;
  logic [2:0]   app_cmd = '0;
  logic         app_en = 1'b0;
  logic [511:0] app_wdf_data = '0;
  logic         app_wdf_end = 1'b0;
  logic         app_wdf_wren = 1'b0;
  logic [511:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rdy;
  logic         app_wdf_rdy;
  logic         init_calib_complete;
  logic [31:0]  o_wr_cnt;
  logic [31:0]  o_rd_cnt;
  logic         o_err;

  ddr_app_mem_model dut (
    .ddr_ui_clk          (ddr_ui_clk),
    .ddr_log_rst         (ddr_log_rst),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_wren        (app_wdf_wren),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rdy             (app_rdy),
    .app_wdf_rdy         (app_wdf_rdy),
    .init_calib_complete (init_calib_complete),
    .o_wr_cnt            (o_wr_cnt),
    .o_rd_cnt            (o_rd_cnt),
    .o_err               (o_err)
  );

  always #5 ddr_ui_clk = ~ddr_ui_clk;

  typedef struct {
    logic [511:0] d;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   vcyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [511:0] PAT_A5 = {64{8'hA5}};
  localparam logic [511:0] PAT_3C = {64{8'h3C}};

  always @(posedge ddr_ui_clk) cyc <= cyc + 1;

  // Monitor: every valid beat must match the oldest queued expectation
  always @(negedge ddr_ui_clk) begin
    if (app_rd_data_valid) begin
      vcyc.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid cyc=%0d data=%h", cyc, app_rd_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (app_rd_data !== e.d) begin
          errors++;
          $display("FAIL rd_data got=%h exp=%h", app_rd_data, e.d);
        end
        if (e.cyc >= 0) begin
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL rd_latency got_cyc=%0d exp_cyc=%0d", cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge ddr_ui_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [29:0] a,
                          output int acc_cyc);
    logic ok;
    logic done;
    done = 1'b0;
    app_cmd = c;
    app_addr = a;
    app_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ok = app_rdy;
      tick(1);
      if (ok) begin
        done = 1'b1;
        break;
      end
    end
    app_en = 1'b0;
    acc_cyc = cyc;
    chk("cmd_accept", {63'd0, done}, 64'd1);
  endtask

  task automatic send_wd(input logic [511:0] d, input logic e);
    logic ok;
    logic done;
    done = 1'b0;
    app_wdf_data = d;
    app_wdf_end = e;
    app_wdf_wren = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ok = app_wdf_rdy;
      tick(1);
      if (ok) begin
        done = 1'b1;
        break;
      end
    end
    app_wdf_wren = 1'b0;
    app_wdf_end = 1'b0;
    chk("wd_accept", {63'd0, done}, 64'd1);
  endtask

  task automatic wr(input logic [29:0] a, input logic [511:0] d);
    int n;
    send_cmd(3'd0, a, n);
    send_wd(d, 1'b1);
  endtask

  task automatic rd(input logic [29:0] a, input logic [511:0] d,
                    input int exp_cyc);
    int n;
    exp_t e;
    e.d = d;
    e.cyc = -1;
    send_cmd(3'd1, a, n);
    if (exp_cyc >= 0) e.cyc = n + 1 + 4;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    tick(2);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic calibrate();
    tick(63);
    chk("calib_low_63", {63'd0, init_calib_complete}, 64'd0);
    chk("rdy_low_63", {62'd0, app_rdy, app_wdf_rdy}, 64'd0);
    tick(1);
    chk("calib_high_64", {63'd0, init_calib_complete}, 64'd1);
    chk("rdy_high_64", {62'd0, app_rdy, app_wdf_rdy}, 64'd3);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_flags"}, {59'd0, app_rd_data_valid, app_rdy, app_wdf_rdy,
        init_calib_complete, o_err}, 64'd0);
    chk({name, "_cnts"}, {o_wr_cnt, o_rd_cnt}, 64'd0);
    chk({name, "_rdata"}, 64'(|app_rd_data), 64'd0);
  endtask

  task automatic reset_cycle();
    app_en = 1'b0;
    app_wdf_wren = 1'b0;
    ddr_log_rst = 1'b1;
    tick(2);
    chk_all_zero("in_reset");
    ddr_log_rst = 1'b0;
    calibrate();
  endtask

  initial begin
    int n;
    exp_t e;

    // Reset release and calibration window
    tick(3);
    chk_all_zero("por");
    ddr_log_rst = 1'b0;
    calibrate();
    chk("err_after_calib", {63'd0, o_err}, 64'd0);
    chk("cnts_after_calib", {o_wr_cnt, o_rd_cnt}, 64'd0);

    // Write then read, fixed latency
    wr(30'h40, PAT_A5);
    rd(30'h40, PAT_A5, 1);
    drain();
    chk("wr_cnt_1", 64'(o_wr_cnt), 64'd1);
    chk("rd_cnt_1", 64'(o_rd_cnt), 64'd1);

    // Command FIFO fills when write data is withheld
    for (int i = 0; i < 4; i++) send_cmd(3'd0, 30'h100 + 30'(i * 8), n);
    chk("rdy_low_full", {63'd0, app_rdy}, 64'd0);
    app_cmd = 3'd0;
    app_addr = 30'h3F8;
    app_en = 1'b1;
    tick(3);
    chk("rdy_still_low", {63'd0, app_rdy}, 64'd0);
    chk("wr_cnt_blocked", 64'(o_wr_cnt), 64'd1);
    app_en = 1'b0;
    for (int i = 0; i < 4; i++) send_wd(512'(i + 100), 1'b1);
    tick(3);
    chk("rdy_back", {63'd0, app_rdy}, 64'd1);
    chk("wr_cnt_5", 64'(o_wr_cnt), 64'd5);

    // Back-to-back reads; plus an aliased address
    for (int i = 0; i < 8; i++) wr(30'(i * 8), 512'(i));
    tick(4);
    vcyc.delete();
    for (int i = 0; i < 8; i++) rd(30'(i * 8), 512'(i), -1);
    drain();
    chk("b2b_count", 64'(vcyc.size()), 64'd8);
    if (vcyc.size() == 8) chk("b2b_contig", 64'(vcyc[7] - vcyc[0]), 64'd7);
    rd(30'h2045, PAT_A5, -1);
    rd(30'h108, 512'd101, -1);
    drain();
    chk("wr_cnt_13", 64'(o_wr_cnt), 64'd13);
    chk("rd_cnt_11", 64'(o_rd_cnt), 64'd11);

    // Illegal command sets sticky error, touches no memory
    chk("err_clear", {63'd0, o_err}, 64'd0);
    send_cmd(3'd3, 30'h8, n);
    tick(3);
    chk("err_cmd3", {63'd0, o_err}, 64'd1);
    rd(30'h8, 512'd1, -1);
    drain();
    chk("err_sticky", {63'd0, o_err}, 64'd1);
    chk("wr_cnt_cmd3", 64'(o_wr_cnt), 64'd13);

    // Missing wdf_end flags error but data is still written
    reset_cycle();
    chk("err_after_rst", {63'd0, o_err}, 64'd0);
    send_cmd(3'd0, 30'h200, n);
    send_wd(PAT_3C, 1'b0);
    chk("err_no_end", {63'd0, o_err}, 64'd1);
    rd(30'h200, PAT_3C, -1);
    drain();
    chk("err_no_end_sticky", {63'd0, o_err}, 64'd1);

    // Async reset with reads in flight
    send_cmd(3'd1, 30'h40, n);
    send_cmd(3'd1, 30'h8, n);
    send_cmd(3'd1, 30'h200, n);
    #3;
    ddr_log_rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick(2);
    ddr_log_rst = 1'b0;
    calibrate();
    rd(30'h40, PAT_A5, -1);
    rd(30'h200, PAT_3C, -1);
    drain();
    chk("post_rst_cnts", {o_wr_cnt, o_rd_cnt}, {32'd0, 32'd2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
